// File: rtl/rgb_fade_sequencer.sv
// Six-phase RGB hue-wheel sequencer with registered per-channel PWM outputs.
// Optional macro FADE_REVERSE_EN adds a `reverse` input sampled at phase boundaries.
module rgb_fade_sequencer #(
    parameter int PWM_INTERVAL    = 1200,
    parameter int STEP_INTERVAL   = 12000,
    parameter int STEPS_PER_PHASE = 200,
    parameter int INC_DEC_VAL     = PWM_INTERVAL / STEPS_PER_PHASE,
    localparam int DW             = $clog2(PWM_INTERVAL + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          enable,
`ifdef FADE_REVERSE_EN
    input  logic          reverse,
`endif
    output logic          pwm_r,
    output logic          pwm_g,
    output logic          pwm_b,
    output logic [DW-1:0] duty_r,
    output logic [DW-1:0] duty_g,
    output logic [DW-1:0] duty_b,
    output logic [2:0]    phase,
    output logic          phase_done
);
    localparam int CW = $clog2(STEP_INTERVAL + 1);
    localparam int SW = $clog2(STEPS_PER_PHASE + 1);
    localparam logic [DW-1:0] FULL_C      = DW'(PWM_INTERVAL);
    localparam logic [DW-1:0] STEP_C      = DW'(INC_DEC_VAL);
    localparam logic [DW-1:0] PWM_LAST_C  = DW'(PWM_INTERVAL - 1);
    localparam logic [CW-1:0] CLK_LAST_C  = CW'(STEP_INTERVAL - 1);
    localparam logic [SW-1:0] STEP_LAST_C = SW'(STEPS_PER_PHASE - 1);

    logic [CW-1:0]        r_clk_count, w_clk_count_nxt;
    logic [SW-1:0]        r_step_count, w_step_count_nxt;
    logic [DW-1:0]        r_pwm_count, w_pwm_count_nxt;
    logic [2:0][DW-1:0]   r_duty, w_duty_nxt;
    logic [2:0]           r_pwm, w_pwm_nxt;
    logic [2:0]           r_phase, w_phase_nxt;
    logic                 r_phase_done, w_phase_done_nxt;
    logic                 w_dir, w_dir_nxt;
    logic                 w_step_tick, w_boundary, w_inc;
    logic [1:0]           w_chan;
    logic [2:0]           w_arrive;

    // Channel index (0=R, 1=G, 2=B) that ramps in a given phase.
    function automatic logic [1:0] ramp_chan(input logic [2:0] ph);
        case (ph)
            3'd0:    ramp_chan = 2'd1;
            3'd1:    ramp_chan = 2'd0;
            3'd2:    ramp_chan = 2'd2;
            3'd3:    ramp_chan = 2'd1;
            3'd4:    ramp_chan = 2'd0;
            3'd5:    ramp_chan = 2'd2;
            default: ramp_chan = 2'd0;
        endcase
    endfunction

    function automatic logic [2:0] phase_inc(input logic [2:0] ph);
        phase_inc = (ph >= 3'd5) ? 3'd0 : ph + 3'd1;
    endfunction

    function automatic logic [2:0] phase_dec(input logic [2:0] ph);
        phase_dec = (ph == 3'd0) ? 3'd5 : ph - 3'd1;
    endfunction

    assign w_step_tick = enable && (r_clk_count == CLK_LAST_C);
    assign w_boundary  = w_step_tick && (r_step_count == STEP_LAST_C);
    assign w_chan      = ramp_chan(r_phase);
    // Even phases increment going forward; reversing swaps the roles.
    assign w_inc       = ~r_phase[0] ^ w_dir;
    assign w_arrive    = w_dir ? r_phase : phase_inc(r_phase);

`ifdef FADE_REVERSE_EN
    logic r_dir;
    assign w_dir = r_dir;

    // Direction is latched only when a phase boundary is crossed.
    always_comb begin
        w_dir_nxt = r_dir;
        if (w_boundary) begin
            w_dir_nxt = reverse;
        end else begin
            w_dir_nxt = r_dir;
        end
    end

    // Direction register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dir <= 1'b0;
        end else begin
            r_dir <= w_dir_nxt;
        end
    end
`else
    assign w_dir     = 1'b0;
    assign w_dir_nxt = 1'b0;
`endif

    // Next-state for counters, duties, phase and PWM drive.
    always_comb begin
        w_clk_count_nxt  = r_clk_count;
        w_step_count_nxt = r_step_count;
        w_pwm_count_nxt  = r_pwm_count;
        w_duty_nxt       = r_duty;
        w_phase_nxt      = r_phase;
        w_pwm_nxt        = 3'b000;
        w_phase_done_nxt = 1'b0;
        if (enable) begin
            w_pwm_count_nxt = (r_pwm_count == PWM_LAST_C) ? {DW{1'b0}} : r_pwm_count + DW'(1);
            w_clk_count_nxt = (r_clk_count == CLK_LAST_C) ? {CW{1'b0}} : r_clk_count + CW'(1);
            w_pwm_nxt       = {r_pwm_count < r_duty[2], r_pwm_count < r_duty[1],
                               r_pwm_count < r_duty[0]};
        end else begin
            w_pwm_nxt = 3'b000;
        end
        if (w_boundary) begin
            // Exact endpoint load so an uneven step size never accumulates drift.
            w_step_count_nxt   = {SW{1'b0}};
            w_duty_nxt[w_chan] = w_inc ? FULL_C : {DW{1'b0}};
            w_phase_nxt        = w_dir_nxt ? phase_dec(w_arrive) : w_arrive;
            w_phase_done_nxt   = 1'b1;
        end else if (w_step_tick) begin
            w_step_count_nxt = r_step_count + SW'(1);
            if (w_inc) begin
                w_duty_nxt[w_chan] = (r_duty[w_chan] >= FULL_C - STEP_C) ? FULL_C
                                                                          : r_duty[w_chan] + STEP_C;
            end else begin
                w_duty_nxt[w_chan] = (r_duty[w_chan] <= STEP_C) ? {DW{1'b0}}
                                                                 : r_duty[w_chan] - STEP_C;
            end
        end else begin
            w_step_count_nxt = r_step_count;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clk_count  <= {CW{1'b0}};
            r_step_count <= {SW{1'b0}};
            r_pwm_count  <= {DW{1'b0}};
            r_duty       <= {{DW{1'b0}}, {DW{1'b0}}, FULL_C};
            r_phase      <= 3'd0;
            r_pwm        <= 3'b000;
            r_phase_done <= 1'b0;
        end else begin
            r_clk_count  <= w_clk_count_nxt;
            r_step_count <= w_step_count_nxt;
            r_pwm_count  <= w_pwm_count_nxt;
            r_duty       <= w_duty_nxt;
            r_phase      <= w_phase_nxt;
            r_pwm        <= w_pwm_nxt;
            r_phase_done <= w_phase_done_nxt;
        end
    end

    assign pwm_r      = r_pwm[0];
    assign pwm_g      = r_pwm[1];
    assign pwm_b      = r_pwm[2];
    assign duty_r     = r_duty[0];
    assign duty_g     = r_duty[1];
    assign duty_b     = r_duty[2];
    assign phase      = r_phase;
    assign phase_done = r_phase_done;

endmodule

// File: tb/tb_rgb_fade_sequencer.sv
// Directed self-checking bench for rgb_fade_sequencer (12/4/3 configuration).
module tb_rgb_fade_sequencer;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic       pwm_r, pwm_g, pwm_b;
    logic [3:0] duty_r, duty_g, duty_b;
    logic [2:0] phase;
    logic       phase_done;
`ifdef FADE_REVERSE_EN
    logic       reverse;
`endif

    int checks   = 0;
    int failures = 0;
    int pd_count = 0;

    // Expected duties / phase after each 12-cycle boundary k (k = 0..6).
    int exp_r [7] = '{12, 12, 0, 0, 0, 12, 12};
    int exp_g [7] = '{0, 12, 12, 12, 0, 0, 0};
    int exp_b [7] = '{0, 0, 0, 12, 12, 12, 0};

    rgb_fade_sequencer #(
        .PWM_INTERVAL    (12),
        .STEP_INTERVAL   (4),
        .STEPS_PER_PHASE (3)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
`ifdef FADE_REVERSE_EN
        .reverse    (reverse),
`endif
        .pwm_r      (pwm_r),
        .pwm_g      (pwm_g),
        .pwm_b      (pwm_b),
        .duty_r     (duty_r),
        .duty_g     (duty_g),
        .duty_b     (duty_b),
        .phase      (phase),
        .phase_done (phase_done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_duty(input string tag, input int r, input int g, input int b);
        check_eq({tag, ".duty_r"}, int'(duty_r), r);
        check_eq({tag, ".duty_g"}, int'(duty_g), g);
        check_eq({tag, ".duty_b"}, int'(duty_b), b);
    endtask

    // Advance n rising edges, sampling 1 time unit after each.
    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (phase_done) pd_count++;
        end
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        enable = 1'b0;
        cycles(2);
        rst_n    = 1'b1;
        pd_count = 0;
    endtask

    initial begin
`ifdef FADE_REVERSE_EN
        reverse = 1'b0;
`endif
        do_reset();
        check_duty("reset", 12, 0, 0);
        check_eq("reset.phase", int'(phase), 0);
        check_eq("reset.pwm", int'({pwm_b, pwm_g, pwm_r}), 0);
        check_eq("reset.phase_done", int'(phase_done), 0);

        // Full wheel from reset.
        enable = 1'b1;
        for (int e = 1; e <= 72; e++) begin
            cycles(1);
            if (e <= 4) begin
                check_eq($sformatf("start.pwm_r@%0d", e), int'(pwm_r), 1);
                check_eq($sformatf("start.pwm_g@%0d", e), int'(pwm_g), 0);
                check_eq($sformatf("start.pwm_b@%0d", e), int'(pwm_b), 0);
            end
            case (e)
                4:  check_eq("ramp.duty_g@4", int'(duty_g), 4);
                8:  check_eq("ramp.duty_g@8", int'(duty_g), 8);
                9:  check_eq("pwm_g_equal_duty@9", int'(pwm_g), 0);
                11: begin
                    check_eq("pre_boundary.phase", int'(phase), 0);
                    check_eq("pre_boundary.phase_done", int'(phase_done), 0);
                    check_eq("pre_boundary.duty_g", int'(duty_g), 8);
                end
                13: begin
                    check_eq("post_boundary.phase_done", int'(phase_done), 0);
                    check_eq("wrap.pwm_g@13", int'(pwm_g), 1);
                end
                16: check_eq("dec.duty_r@16", int'(duty_r), 8);
                default: ;
            endcase
            if (e % 12 == 0) begin
                check_duty($sformatf("boundary%0d", e / 12),
                           exp_r[e / 12], exp_g[e / 12], exp_b[e / 12]);
                check_eq($sformatf("boundary%0d.phase", e / 12), int'(phase), (e / 12) % 6);
                check_eq($sformatf("boundary%0d.phase_done", e / 12), int'(phase_done), 1);
            end
        end
        check_eq("wheel.phase_done_pulses", pd_count, 6);

        // Hold with enable low mid-phase 1.
        do_reset();
        enable = 1'b1;
        cycles(17);
        check_duty("pre_hold", 8, 12, 0);
        check_eq("pre_hold.phase", int'(phase), 1);
        enable = 1'b0;
        cycles(1);
        check_eq("hold.pwm", int'({pwm_b, pwm_g, pwm_r}), 0);
        cycles(19);
        check_duty("hold", 8, 12, 0);
        check_eq("hold.phase", int'(phase), 1);
        check_eq("hold.pwm_after", int'({pwm_b, pwm_g, pwm_r}), 0);
        check_eq("hold.phase_done", int'(phase_done), 0);
        enable = 1'b1;
        cycles(1);
        check_eq("resume.pwm_r", int'(pwm_r), 1);
        check_eq("resume1.duty_r", int'(duty_r), 8);
        cycles(1);
        check_eq("resume2.duty_r", int'(duty_r), 8);
        cycles(1);
        check_eq("resume3.duty_r", int'(duty_r), 4);

        // Asynchronous reset in phase 3 (20 enabled cycles done, 20 more -> 40).
        cycles(20);
        check_eq("phase3.phase", int'(phase), 3);
        check_duty("phase3", 0, 8, 12);
        check_eq("phase3.pwm_g", int'(pwm_g), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_duty("async_reset", 12, 0, 0);
        check_eq("async_reset.phase", int'(phase), 0);
        check_eq("async_reset.pwm", int'({pwm_b, pwm_g, pwm_r}), 0);
        check_eq("async_reset.phase_done", int'(phase_done), 0);

`ifdef FADE_REVERSE_EN
        do_reset();
        reverse = 1'b1;
        enable  = 1'b1;
        cycles(12);
        check_duty("rev.first", 12, 12, 0);
        cycles(4);
        check_eq("rev.g8", int'(duty_g), 8);
        check_eq("rev.seg0.phase", int'(phase), 0);
        cycles(4);
        check_eq("rev.g4", int'(duty_g), 4);
        cycles(4);
        check_duty("rev.seg0_end", 12, 0, 0);
        check_eq("rev.seg5.phase", int'(phase), 5);
        cycles(4);
        check_eq("rev.b4", int'(duty_b), 4);
        cycles(4);
        check_eq("rev.b8", int'(duty_b), 8);
        check_eq("rev.seg5.phase_mid", int'(phase), 5);
        cycles(4);
        check_duty("rev.seg5_end", 12, 0, 12);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rgb_fade_sequencer.md
Name: rgb_fade_sequencer

Overview:
- Colour-wheel controller for an RGB LED.
- Sequences three PWM duty channels through a 6-phase hue wheel. In each phase one channel ramps up or down by a fixed step on a slow tick while the other two hold.
- Contains the per-channel PWM comparators and drives the LED pins directly.
- Sits between the board clock and the top-level RGB outputs.

Parameters:
- PWM_INTERVAL, 1200: PWM period in clk cycles; full-scale duty value.
- STEP_INTERVAL, 12000: clk cycles between duty steps (1 ms at 12 MHz).
- STEPS_PER_PHASE, 200: steps per hue phase.
- INC_DEC_VAL, PWM_INTERVAL/STEPS_PER_PHASE: duty change per step.

Ports:
- clk  input  1  system clock, 12 MHz
- rst_n  input  1  asynchronous active-low reset
- enable  input  1  run/hold; low freezes the sequence and blanks the LEDs
- pwm_r, pwm_g, pwm_b  output  1 each  registered PWM drive, active high
- duty_r, duty_g, duty_b  output  $clog2(PWM_INTERVAL+1) each  current duty
- phase  output  3  current segment index, 0..5
- phase_done  output  1  one-cycle pulse at each phase boundary

Behaviour:
- Reset (asserted asynchronously, released synchronously to clk) sets:
  - clk_count=0, step_count=0, pwm_count=0, phase=0.
  - duty=(PWM_INTERVAL,0,0).
  - pwm_r/g/b=0, phase_done=0.
- Reset mid-operation takes effect immediately, with no clock edge needed.
- pwm_count runs 0..PWM_INTERVAL-1 and wraps while enable=1.
- pwm_x is registered from (pwm_count < duty_x), giving 1-cycle latency.
  - duty=0 gives pwm_x constantly 0.
  - duty=PWM_INTERVAL gives pwm_x constantly 1.
- clk_count runs 0..STEP_INTERVAL-1 while enable=1. step_tick is internal, one cycle, at clk_count==STEP_INTERVAL-1.
- Phase action table, as (R,G,B), with H=hold high, L=hold low, I=inc, D=dec:
  - 0: H,I,L
  - 1: D,H,L
  - 2: L,H,I
  - 3: L,D,H
  - 4: I,L,H
  - 5: H,L,D
- On step_tick with step_count < STEPS_PER_PHASE-1:
  - step_count++.
  - The I channel gets += INC_DEC_VAL and the D channel gets -= INC_DEC_VAL.
  - Results saturate at PWM_INTERVAL and at 0; no wrap-around is permitted.
- On step_tick with step_count == STEPS_PER_PHASE-1 (phase boundary):
  - step_count=0.
  - The ramping channel is loaded with its exact endpoint (I channel gets PWM_INTERVAL, D channel gets 0), so there is no drift when the step size does not divide evenly.
  - phase advances, with 5 wrapping to 0.
  - phase_done=1 for exactly that one cycle.
- enable=0:
  - All counters, duties and phase hold.
  - pwm_r/g/b are forced to 0 on the next edge.
  - phase_done=0.
- Re-asserting enable resumes from the exact held counts; no tick is lost or duplicated.
- enable falling on the same cycle as step_tick: the tick is suppressed.
- Full wheel = 6*STEPS_PER_PHASE*STEP_INTERVAL cycles; duties then return to (PWM_INTERVAL,0,0).

Optional Feature:
- Macro: FADE_REVERSE_EN.
- Defined:
  - Adds an input port `reverse` (1 bit).
  - An internal dir register (reset 0 = forward) samples `reverse` only at phase boundaries; mid-phase changes are ignored until the next boundary.
  - Boundary position p is the start of phase p.
  - Forward from p: traverse phase p and arrive at p+1.
  - Reverse from p: traverse phase p-1 (mod 6) with I/D swapped and arrive at p-1. phase reports the segment being traversed.
  - Endpoint loads follow the swapped roles.
- Undefined: no `reverse` port; the sequence is always forward.

Test Plan:
All tests use PWM_INTERVAL=12, STEP_INTERVAL=4, STEPS_PER_PHASE=3 (INC_DEC_VAL=4).
- Reset, then enable=1:
  - duty=(12,0,0), phase=0.
  - pwm_r=1 from the second cycle onward; pwm_g=pwm_b=0 throughout the first 4 cycles.
- Run 12 enabled cycles:
  - duty_g goes 4, 8, then the boundary loads 12.
  - phase=1 and phase_done is high for exactly 1 cycle.
  - Then duty_r steps 12→8.
- Run 72 enabled cycles from reset:
  - phase sequence is 0..5 then back to 0.
  - Exactly 6 phase_done pulses.
  - duty is back to (12,0,0).
- At cycle 17 (phase 1, duty_r=8), drop enable for 20 cycles:
  - pwm_* are 0 from the next cycle.
  - duty and phase are unchanged.
  - After re-enabling, the next duty_r change (to 4) occurs exactly 3 enabled cycles later.
- In phase 3, assert rst_n=0 between clock edges:
  - Outputs are at their reset values immediately (duty=(12,0,0), phase=0, pwm_*=0) before the next edge.
- FADE_REVERSE_EN, reverse=1 from reset:
  - First boundary is forward (dir resets to 0), arriving at duty=(12,12,0).
  - Next segment is phase 0 reversed: duty_g goes 8, 4, 0.
  - Next segment is phase 5 reversed: duty_b goes 4, 8, 12, with phase=5.
